// File: rtl/mp_addsub_pkg.sv
// rtl/mp_addsub_pkg.sv - shared types, constants and helpers for the multi-precision add/sub sequencer
package mp_addsub_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for an index over n items; never returns 0 so a
    // single-byte build still gets a legal one-bit index register.
    function automatic int clog2_nz(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/addsub_slice8.sv
// rtl/addsub_slice8.sv - combinational 8-bit add/sub slice with carry in/out
//
// Ports:
//   a    : first operand byte
//   b    : second operand byte (inverted when sub=1)
//   sub  : 1 inverts b so that a + ~b + cin forms a subtraction step
//   cin  : carry in from the previous byte
//   s    : sum byte
//   cout : carry out to the next byte
module addsub_slice8
    import mp_addsub_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              sub,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    logic [BYTE_W-1:0] xb;

    assign xb = b ^ {BYTE_W{sub}};
    assign {cout, s} = {1'b0, a} + {1'b0, xb} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/mp_addsub_seq.sv
// rtl/mp_addsub_seq.sv - byte-serial multi-precision add/sub sequencer with valid/ready handshakes
//
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   in_valid / in_ready  : operand handshake; in_ready is high only in IDLE
//   in_a, in_b, in_sub   : operands and operation select (1 = a-b, 0 = a+b)
//   out_valid/out_ready  : result handshake; result held until accepted
//   out_s                : W-bit result modulo 2^W
//   out_co               : add carry out, or borrow (a < b unsigned) for sub
//   out_ofl              : signed two's-complement overflow
//   busy                 : high whenever the sequencer is not IDLE
module mp_addsub_seq
    import mp_addsub_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = NBYTES * BYTE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_s,
    output logic         out_co,
    output logic         out_ofl,
    output logic         busy
);

    localparam int            IW       = clog2_nz(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t state_q, state_d;

    logic [NBYTES-1:0][BYTE_W-1:0] a_q, b_q, s_q;
    logic                          sub_q;
    logic                          carry_q;
    logic [IW-1:0]                 idx_q;
    logic                          co_q, ofl_q;

    logic              accept;
    logic              last_byte;
    logic [BYTE_W-1:0] slice_s;
    logic              slice_cout;
    logic              xb_msb;

    assign accept    = in_valid && (state_q == IDLE);
    assign last_byte = (idx_q == LAST_IDX);

    addsub_slice8 u_slice (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .sub  (sub_q),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_byte) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Datapath: operands only load in IDLE, so in_b/in_sub activity while
    // busy cannot disturb the running operation.
    assign xb_msb = b_q[NBYTES-1][BYTE_W-1] ^ sub_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            co_q    <= 1'b0;
            ofl_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        sub_q   <= in_sub;
                        // Seeding the carry with sub supplies the +1 of a + ~b + 1.
                        carry_q <= in_sub;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    s_q[idx_q] <= slice_s;
                    carry_q    <= slice_cout;
                    if (last_byte) begin
                        idx_q <= '0;
                        // Subtraction carry out is the inverse of borrow.
                        co_q  <= slice_cout ^ sub_q;
                        ofl_q <= (a_q[NBYTES-1][BYTE_W-1] & xb_msb & ~slice_s[BYTE_W-1]) |
                                 (~a_q[NBYTES-1][BYTE_W-1] & ~xb_msb & slice_s[BYTE_W-1]);
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_s   = s_q;
    assign out_co  = co_q;
    assign out_ofl = ofl_q;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// tb/tb_mp_addsub_seq.sv - directed self-checking bench for mp_addsub_seq
module tb_mp_addsub_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_s;
    logic         out_co;
    logic         out_ofl;
    logic         busy;

    int total = 0;
    int bad   = 0;

    mp_addsub_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_co    (out_co),
        .out_ofl   (out_ofl),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {s, co, ofl} from full-width arithmetic.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sub);
        logic [W:0] r;
        logic       ofl;
        if (sub) begin
            r   = {1'b0, a} - {1'b0, b};
            ofl = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r   = {1'b0, a} + {1'b0, b};
            ofl = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {r[W-1:0], r[W], ofl};
    endfunction

    // One complete operation with out_ready high; checks latency and result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] es, input logic eco,
                          input logic eofl);
        int n;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'd5);
        chk({tag, ".result"}, {31'd0, out_s, out_co, out_ofl}, {31'd0, es, eco, eofl});
        step();
        chk({tag, ".drop"}, 64'(out_valid), 64'd0);
    endtask

    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic         vs [8];
    logic [W+1:0] e;
    int nacc, nres, cyc, last_acc, n;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset_state", {26'd0, in_ready, out_valid, busy, out_s, out_co, out_ofl},
            {26'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0});

        // Carry across byte 0 -> 1, signed overflow, wrap, borrow.
        run_op("add_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_op("add_ofl",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("sub_borrow",32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("sub_ofl",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);

        // Back-pressure with a second operand set offered throughout.
        in_a      = 32'hFFFF_FFFF;
        in_b      = 32'h0000_0002;
        in_sub    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_a   = 32'h0000_0005;
        in_b   = 32'h0000_0007;
        in_sub = 1'b1;
        n = 1;
        while (!out_valid && n < 20) begin
            chk("bp.in_ready_run", 64'(in_ready), 64'd0);
            step();
            n++;
        end
        chk("bp.latency", 64'(n), 64'd5);
        chk("bp.result", {31'd0, out_s, out_co, out_ofl}, {31'd0, 32'h0000_0001, 1'b1, 1'b0});
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp.hold", {29'd0, out_valid, in_ready, out_s, out_co, out_ofl},
                {29'd0, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        step();
        chk("bp.release", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("bp.second_latency", 64'(n), 64'd5);
        chk("bp.second_result", {31'd0, out_s, out_co, out_ofl},
            {31'd0, 32'hFFFF_FFFE, 1'b1, 1'b0});
        step();

        // Reset on the second RUN cycle aborts the operation.
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h0000_0001;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("abort.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.state", {26'd0, in_ready, out_valid, busy, out_s, out_co, out_ofl},
            {26'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0});
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort.no_valid", {62'd0, out_valid, busy}, 64'd0);
        end

        // Reset wins over a simultaneous in_valid.
        in_valid = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_vs_valid", {62'd0, busy, in_ready}, {62'd0, 1'b0, 1'b1});
        step();
        chk("rst_vs_valid.idle", 64'(busy), 64'd0);

        run_op("post_abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // Back-to-back stream, in_valid and out_ready held high.
        for (int i = 0; i < 8; i++) begin
            va[i] = $urandom();
            vb[i] = $urandom();
            vs[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        nacc      = 0;
        nres      = 0;
        last_acc  = 0;
        cyc       = 0;
        while (nres < 8 && cyc < 200) begin
            if (out_valid) begin
                e = ref_model(va[nres], vb[nres], vs[nres]);
                chk("stream.result", {30'd0, out_s, out_co, out_ofl}, {30'd0, e});
                nres++;
            end
            if (in_ready) begin
                if (nacc < 8) begin
                    in_a     = va[nacc];
                    in_b     = vb[nacc];
                    in_sub   = vs[nacc];
                    in_valid = 1'b1;
                    if (nacc > 0) begin
                        chk("stream.interval", 64'(cyc - last_acc), 64'd6);
                    end
                    last_acc = cyc;
                    nacc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            step();
            cyc++;
        end
        chk("stream.count", 64'(nres), 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mp_addsub_seq.md
Name: mp_addsub_seq

Overview:
Multi-precision add/subtract sequencer that reuses one 8-bit add/sub slice over NBYTES cycles. Each cycle processes one byte, least-significant byte first, and chains the carry between bytes. It gives wide (for example 32-bit) add/sub at the area cost of a single byte slice. Operands arrive and results leave over valid/ready handshakes.

Parameters:
NBYTES, 4, operand width in bytes; legal range is NBYTES >= 1.
W, 8*NBYTES, derived operand width in bits; not overridable.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand set offered.
in_ready  output  1  block can accept an operand set; high only in IDLE.
in_a  input  W  minuend/augend.
in_b  input  W  subtrahend/addend.
in_sub  input  1  1 = a-b, 0 = a+b.
out_valid  output  1  result held stable until accepted.
out_ready  input  1  consumer accepts the result.
out_s  output  W  result, modulo 2^W.
out_co  output  1  add: carry out; sub: borrow (1 when unsigned a < b).
out_ofl  output  1  signed two's-complement overflow.
busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- State after reset: IDLE, with in_ready=1, out_valid=0, busy=0, out_s=0, out_co=0, out_ofl=0, byte index=0, carry register=0.
- FSM states are IDLE, RUN and DONE.
- IDLE to RUN on in_valid & in_ready:
  - register a, b and sub;
  - load the carry register with sub, so subtraction computes a + ~b + 1;
  - set the byte index to 0.
- RUN, byte slice each cycle k:
  - {c, s_k} = a_k + (b_k ^ {8{sub}}) + carry;
  - write s_k into out_s[8k+7:8k];
  - carry <= c;
  - k increments each cycle.
- RUN to DONE on the cycle k == NBYTES-1. In that cycle also latch:
  - out_co = c ^ sub;
  - out_ofl = (a_msb & xb_msb & ~s_msb) | (~a_msb & ~xb_msb & s_msb), where xb_msb = b_msb ^ sub.
- DONE:
  - out_valid=1;
  - out_s, out_co and out_ofl are held stable while out_ready=0 (back-pressure of any length);
  - on out_ready, go to IDLE and drop out_valid the next cycle.
- Latency: acceptance edge to out_valid is NBYTES+1 cycles; throughput is one operation per NBYTES+2 cycles.
- in_ready is low in RUN and DONE; in_valid is ignored there and nothing is lost or queued.
- out_s bytes not yet written during RUN are don't-care; out_s is defined only while out_valid=1.
- Wrap-around: the byte index never exceeds NBYTES-1. When NBYTES=1, RUN lasts exactly one cycle.
- rst asserted in RUN or DONE aborts the operation at the next edge:
  - all outputs return to their reset values;
  - the pending result is discarded; no out_valid pulse occurs.
- rst together with in_valid: reset wins and the operand set is not accepted.
- Ports are 2-state clean: no X propagates from an unused in_b when in_sub toggles outside IDLE.

Decomposition:
- Package mp_addsub_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  - BYTE_W = 8;
  - function clog2_nz(n) for counter width, returning at least 1.
- One sub-module, addsub_slice8: combinational 8-bit slice with ports a[7:0], b[7:0], sub, cin, s[7:0], cout.
  - It computes a + (b ^ {8{sub}}) + cin.
  - The sequencer instantiates it once.
  - The sequencer owns all state, the carry register, the index, and the flag formation.

Test Plan:
(All cases use NBYTES=4.)
1. a=0x000000FF, b=0x00000001, sub=0 -> out_s=0x00000100, co=0, ofl=0; out_valid exactly 5 cycles after acceptance; carry propagates across bytes 0 to 1.
2. a=0x7FFFFFFF, b=0x00000001, sub=0 -> out_s=0x80000000, co=0, ofl=1. Then a=0xFFFFFFFF, b=0x00000001, sub=0 -> out_s=0x00000000, co=1, ofl=0.
3. a=0x00000000, b=0x00000001, sub=1 -> out_s=0xFFFFFFFF, co=1 (borrow), ofl=0. Then a=0x80000000, b=0x00000001, sub=1 -> out_s=0x7FFFFFFF, co=0, ofl=1.
4. Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> out_s, out_co and out_ofl stay unchanged and in_ready=0 throughout. Keep in_valid=1 with new operands during RUN/DONE -> those operands are not accepted until after the handshake; the second op then yields its own correct result.
5. Reset mid-operation: assert rst on the 2nd RUN cycle -> next cycle busy=0, in_ready=1, out_valid=0, outputs zero. A following op 0x12345678+0x11111111 gives 0x23456789, co=0, ofl=0.
6. Back-to-back: out_ready tied 1 and in_valid tied 1 with a stream of 8 random operand pairs and random sub -> each result matches a W-bit reference model (sum/difference, borrow, signed overflow); in_ready pulses once every 6 cycles.
